// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: edge-detected capture, FWFT read port, sticky overrun.
// Optional threshold flag enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
`ifdef UART_RX_FIFO_THRESH_EN
    ,
    parameter int THRESH = DEPTH / 2
`endif
) (
    input  logic              uart_clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef UART_RX_FIFO_THRESH_EN
    ,
    output logic              thresh_hit
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rx_valid_q;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              drop;

    assign empty    = (count == '0);
    assign full     = (count == (ADDR_W + 1)'(DEPTH));
    assign rd_valid = ~empty;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // One write per rising edge of rx_valid; a pop frees the slot when full.
    assign push  = rx_valid & ~rx_valid_q;
    assign pop   = rd_valid & rd_ready;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge uart_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overrun    <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr_en) begin
                count <= count - 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_THRESH_EN
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            thresh_hit <= 1'b0;
        end else begin
            thresh_hit <= (count >= (ADDR_W + 1)'(THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic against a queue model.
// Define UART_RX_FIFO_THRESH_EN to also check thresh_hit.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int THR    = DEPTH / 2;

    logic              uart_clk;
    logic              rst_n;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic              overrun;
    logic              overrun_clr;
`ifdef UART_RX_FIFO_THRESH_EN
    logic              thresh_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queue plus the few flags the FIFO keeps.
    logic [7:0] q[$];
    bit         m_prev   = 1'b1;
    bit         m_ovr    = 1'b0;
    bit         m_thresh = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .uart_clk    (uart_clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef UART_RX_FIFO_THRESH_EN
        ,
        .thresh_hit  (thresh_hit)
`endif
    );

    initial uart_clk = 1'b0;
    always #5 uart_clk = ~uart_clk;

    // Advance one clock and apply the same edge to the model; inputs change only #1 after an edge.
    task automatic tick();
        int         pre;
        bit         push;
        bit         pop;
        bit         drop;
        logic [7:0] din;
        logic [7:0] dummy;
        pre  = q.size();
        push = rx_valid && !m_prev;
        pop  = rd_ready && (pre != 0);
        drop = push && (pre == DEPTH) && !pop;
        din  = rx_data;
        @(posedge uart_clk);
        if (!rst_n) begin
            q.delete();
            m_prev   = 1'b1;
            m_ovr    = 1'b0;
            m_thresh = 1'b0;
        end else begin
            m_thresh = (pre >= THR);
            if (pop) dummy = q.pop_front();
            if (push && !drop) q.push_back(din);
            if (drop) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
            m_prev = rx_valid;
        end
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rd_ready    = 1'b0;
        overrun_clr = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        rx_valid    = 1'b1;
        rx_data     = 8'hFF;
        rd_ready    = 1'b0;
        overrun_clr = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({count, empty, full, rd_valid, rd_data, overrun} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got count=%0d empty=%b full=%b rd_valid=%b rd_data=%h overrun=%b, expected 0 1 0 0 00 0",
                     count, empty, full, rd_valid, rd_data, overrun);
        end
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        tick();
        n_checks++;
        if ({rd_valid, rd_data, count, empty} !== {1'b1, 8'hA5, 5'd1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL first_push: got rd_valid=%b rd_data=%h count=%0d empty=%b, expected 1 a5 1 0",
                     rd_valid, rd_data, count, empty);
        end
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold_strobe();
        do_reset();
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        for (int i = 0; i < 5; i++) tick();
        rx_valid = 1'b0;
        tick();
        n_checks++;
        if ({count, rd_data} !== {5'd1, 8'h3C}) begin
            n_fail++;
            $display("[TB] FAIL hold_strobe: got count=%0d rd_data=%h, expected 1 3c", count, rd_data);
        end
    endtask

    task automatic test_full_overrun();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        n_checks++;
        if ({full, count, overrun} !== {1'b1, 5'd16, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL fill: got full=%b count=%0d overrun=%b, expected 1 16 0", full, count, overrun);
        end
        push_byte(8'h10);
        n_checks++;
        if ({overrun, count} !== {1'b1, 5'd16}) begin
            n_fail++;
            $display("[TB] FAIL drop: got overrun=%b count=%0d, expected 1 16", overrun, count);
        end
        overrun_clr = 1'b1;
        rx_valid    = 1'b1;
        rx_data     = 8'h11;
        tick();
        overrun_clr = 1'b0;
        rx_valid    = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL set_wins: got overrun=%b, expected 1", overrun);
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overrun_clr: got overrun=%b, expected 0", overrun);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if ({rd_valid, rd_data} !== {1'b1, 8'(i)}) begin
                n_fail++;
                $display("[TB] FAIL drain_order[%0d]: got valid=%b data=%h, expected 1 %h", i, rd_valid, rd_data, 8'(i));
            end
            tick();
        end
        rd_ready = 1'b0;
        n_checks++;
        if ({empty, rd_valid, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL drained: got empty=%b rd_valid=%b rd_data=%h, expected 1 0 00", empty, rd_valid, rd_data);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        rd_ready = 1'b1;
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL full_pp_head: got %h, expected 00", rd_data);
        end
        tick();
        rx_valid = 1'b0;
        rd_ready = 1'b0;
        n_checks++;
        if ({count, overrun} !== {5'd16, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL full_pp_state: got count=%0d overrun=%b, expected 16 0", count, overrun);
        end
        rd_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            exp = (i == DEPTH) ? 8'h55 : 8'(i);
            n_checks++;
            if (rd_data !== exp) begin
                n_fail++;
                $display("[TB] FAIL full_pp_order[%0d]: got %h, expected %h", i, rd_data, exp);
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp_data;
        int         push_pct;
        int         pop_pct;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            push_pct    = (cyc < 200) ? 70 : ((cyc < 400) ? 50 : 25);
            pop_pct     = (cyc < 200) ? 15 : ((cyc < 400) ? 50 : 80);
            rx_valid    = ($urandom_range(99) < push_pct);
            rx_data     = 8'($urandom);
            rd_ready    = ($urandom_range(99) < pop_pct);
            overrun_clr = ($urandom_range(99) < 8);
            exp_data    = (q.size() != 0) ? q[0] : 8'h00;
            n_checks++;
            if ({count, full, empty, rd_valid, rd_data, overrun} !==
                {5'(q.size()), q.size() == DEPTH, q.size() == 0, q.size() != 0, exp_data, m_ovr}) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: got count=%0d full=%b empty=%b valid=%b data=%h ovr=%b, expected %0d %b %b %b %h %b",
                         cyc, count, full, empty, rd_valid, rd_data, overrun,
                         q.size(), q.size() == DEPTH, q.size() == 0, q.size() != 0, exp_data, m_ovr);
            end
`ifdef UART_RX_FIFO_THRESH_EN
            n_checks++;
            if (thresh_hit !== m_thresh) begin
                n_fail++;
                $display("[TB] FAIL random_thresh[%0d]: got %b, expected %b", cyc, thresh_hit, m_thresh);
            end
`endif
            tick();
        end
        rx_valid    = 1'b0;
        rd_ready    = 1'b0;
        overrun_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) push_byte(8'(8'h40 + i));
        n_checks++;
        if (count !== 5'd7) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_count: got %0d, expected 7", count);
        end
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        tick();
        n_checks++;
        if ({count, rd_valid, rd_data, overrun} !== {5'd0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got count=%0d rd_valid=%b rd_data=%h overrun=%b, expected 0 0 00 0",
                     count, rd_valid, rd_data, overrun);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (count !== 5'd0) begin
            n_fail++;
            $display("[TB] FAIL held_across_reset: got count=%0d, expected 0", count);
        end
        rx_valid = 1'b0;
        tick();
    endtask

`ifdef UART_RX_FIFO_THRESH_EN
    task automatic test_thresh();
        do_reset();
        for (int i = 0; i < THR - 1; i++) push_byte(8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if ({count, thresh_hit} !== {5'(THR), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL thresh_lag: got count=%0d thresh_hit=%b, expected %0d 0", count, thresh_hit, THR);
        end
        tick();
        n_checks++;
        if (thresh_hit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL thresh_hit: got %b, expected 1", thresh_hit);
        end
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        rd_ready    = 1'b0;
        overrun_clr = 1'b0;
        test_reset();
        test_hold_strobe();
        test_full_overrun();
        test_full_push_pop();
        test_random();
        test_reset_mid();
`ifdef UART_RX_FIFO_THRESH_EN
        test_thresh();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
